// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
package if_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Fetch-side controller: drives the PC register, runs the req/ack
// instruction-memory handshake and loads the IF/ID pipeline register.
//
// state  | meaning
// S_IDLE | after reset; latch the first fetch address (no request)
// S_REQ  | request outstanding at req_addr, waiting for imem_ack
// S_HOLD | fetched word parked in hold_instr while ID is stalled
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] NOP_INSTR = if_fetch_ctrl_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic [ADDR_W-1:0] npc,
  output logic              PCWrite,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              id_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [ADDR_W-1:0] imem_rdata,
  output logic              ifid_valid,
  output logic [ADDR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] req_addr, req_addr_nxt;
  logic [ADDR_W-1:0] hold_instr, hold_instr_nxt;
  logic              drop, drop_nxt;
  logic              deliver;
  logic [ADDR_W-1:0] deliver_instr;
  logic [ADDR_W-1:0] target_aligned;
  logic [ADDR_W-1:0] seq_addr;

  assign target_aligned = {redirect_target[ADDR_W-1:2], 2'b00};
  assign seq_addr       = req_addr + ADDR_W'(INSTR_BYTES);
  assign npc            = redirect ? target_aligned : seq_addr;
  assign imem_addr      = req_addr;
  assign imem_req       = (state == S_REQ);

  // FSM state, fetch address, wrong-path drop flag and parked instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      req_addr   <= '0;
      drop       <= 1'b0;
      hold_instr <= '0;
    end else begin
      state      <= state_nxt;
      req_addr   <= req_addr_nxt;
      drop       <= drop_nxt;
      hold_instr <= hold_instr_nxt;
    end
  end

  // Next-state, PC load enable and instruction-delivery decode
  always_comb begin
    state_nxt      = state;
    req_addr_nxt   = req_addr;
    drop_nxt       = drop;
    hold_instr_nxt = hold_instr;
    PCWrite        = redirect;
    deliver        = 1'b0;
    deliver_instr  = hold_instr;

    case (state)
      S_IDLE: begin
        state_nxt    = S_REQ;
        req_addr_nxt = redirect ? target_aligned : pc_addr;
      end

      S_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            // completing word is wrong-path; restart at the new target
            req_addr_nxt = target_aligned;
            drop_nxt     = 1'b0;
          end else if (drop) begin
            // stale word from before an earlier redirect; PC already holds the target
            drop_nxt     = 1'b0;
            req_addr_nxt = pc_addr;
          end else if (id_stall) begin
            hold_instr_nxt = imem_rdata;
            state_nxt      = S_HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            PCWrite       = 1'b1;
            req_addr_nxt  = seq_addr;
          end
        end else if (redirect) begin
          // address must stay stable until ack, so only mark the word for discard
          drop_nxt = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          req_addr_nxt = target_aligned;
          state_nxt    = S_REQ;
        end else if (!id_stall) begin
          deliver      = 1'b1;
          PCWrite      = 1'b1;
          req_addr_nxt = seq_addr;
          state_nxt    = S_REQ;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // IF/ID register: flush on redirect, load on delivery, hold on stall, else bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= '0;
    end else if (redirect) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
    end else if (deliver) begin
      ifid_valid <= 1'b1;
      ifid_instr <= deliver_instr;
      ifid_pc    <= req_addr;
    end else if (!id_stall) begin
      ifid_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed cycle table, async reset
// and wrap checks, then randomized traffic against a program-order model.
module tb_if_fetch_ctrl;
  import if_fetch_ctrl_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pc_addr, npc, redirect_target, imem_addr, imem_rdata;
  logic [W-1:0] ifid_instr, ifid_pc;
  logic         PCWrite, redirect, id_stall, imem_req, imem_ack, ifid_valid;

  int total = 0;
  int bad   = 0;

  // memory model state
  logic         mem_busy;
  int           mem_wait;
  logic [W-1:0] mem_addr;

  typedef struct {
    logic         rd;
    logic [W-1:0] tgt;
    logic         st;
    logic         ack;
    logic         req;
    logic [W-1:0] addr;
    logic         pcw;
    logic [W-1:0] npc;
    logic         val;
    logic [W-1:0] pc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  if_fetch_ctrl #(.ADDR_W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_addr        (pc_addr),
    .npc            (npc),
    .PCWrite        (PCWrite),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .id_stall       (id_stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc)
  );

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return 32'h1111_0000 + ((a - 32'h0000_3000) >> 2);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [W-1:0] rpc);
    redirect        = 1'b0;
    redirect_target = '0;
    id_stall        = 1'b0;
    imem_ack        = 1'b0;
    imem_rdata      = 32'hDEAD_BEEF;
    pc_addr         = rpc;
    mem_busy        = 1'b0;
    mem_wait        = 0;
    rst             = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Applies table rows lo..hi, one per clock; entered and left at posedge+1.
  task automatic run_vec(input int lo, input int hi);
    logic         s_pcw;
    logic [W-1:0] s_npc;
    for (int i = lo; i <= hi; i++) begin
      redirect        = vecs[i].rd;
      redirect_target = vecs[i].tgt;
      id_stall        = vecs[i].st;
      imem_ack        = vecs[i].ack;
      imem_rdata      = vecs[i].ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
      @(negedge clk);
      check($sformatf("row%0d imem_req", i), W'(imem_req), W'(vecs[i].req));
      check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("row%0d PCWrite", i), W'(PCWrite), W'(vecs[i].pcw));
      check($sformatf("row%0d npc", i), npc, vecs[i].npc);
      check($sformatf("row%0d ifid_valid", i), W'(ifid_valid), W'(vecs[i].val));
      if (vecs[i].val) begin
        check($sformatf("row%0d ifid_pc", i), ifid_pc, vecs[i].pc);
        check($sformatf("row%0d ifid_instr", i), ifid_instr, mem_word(vecs[i].pc));
      end
      s_pcw = PCWrite;
      s_npc = npc;
      @(posedge clk);
      #1;
      if (s_pcw) pc_addr = s_npc;
    end
  endtask

  initial begin
    logic         r_red, r_stall, s_pcw, s_valid, done;
    logic [W-1:0] r_tgt, s_npc, s_instr, s_pc, exp_pc;
    int           deliveries, quiet;

    // rd tgt st ack | req addr pcw npc val pc
    // section A: rows 0..20, from reset with PC=0x3000
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0004, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_3004, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_3004, 1'b1, 32'h0000_3008, 1'b1, 32'h0000_3000});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_3008, 1'b1, 32'h0000_300C, 1'b1, 32'h0000_3004});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'h0000_300C, 1'b0, 32'h0000_3010, 1'b1, 32'h0000_3008});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'h0000_300C, 1'b0, 32'h0000_3010, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'h0000_300C, 1'b0, 32'h0000_3010, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_300C, 1'b1, 32'h0000_3010, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h0000_3010, 1'b0, 32'h0000_3014, 1'b1, 32'h0000_300C});
    vecs.push_back('{1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0000_3010, 1'b0, 32'h0000_3014, 1'b1, 32'h0000_300C});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0000_3010, 1'b1, 32'h0000_3014, 1'b1, 32'h0000_300C});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'h0000_3014, 1'b0, 32'h0000_3018, 1'b1, 32'h0000_3010});
    vecs.push_back('{1'b1, 32'h0000_3403, 1'b0, 1'b0, 1'b1, 32'h0000_3014, 1'b1, 32'h0000_3400, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_3014, 1'b0, 32'h0000_3018, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_3400, 1'b1, 32'h0000_3404, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h0000_3404, 1'b0, 32'h0000_3408, 1'b1, 32'h0000_3400});
    vecs.push_back('{1'b1, 32'h0000_5002, 1'b1, 1'b0, 1'b0, 32'h0000_3404, 1'b1, 32'h0000_5000, 1'b1, 32'h0000_3400});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'h0000_5000, 1'b0, 32'h0000_5004, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_6000, 1'b0, 1'b1, 1'b1, 32'h0000_5000, 1'b1, 32'h0000_6000, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0000_6000, 1'b1, 32'h0000_6004, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'h0000_6004, 1'b0, 32'h0000_6008, 1'b1, 32'h0000_6000});
    // section B: rows 21..24, address wrap from a redirect in S_IDLE
    vecs.push_back('{1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC});

    // reset state, checked before the first clock edge
    redirect = 1'b0; redirect_target = '0; id_stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; pc_addr = 32'h0000_3000;
    mem_busy = 1'b0; mem_wait = 0; mem_addr = '0;
    rst = 1'b1;
    #3;
    check("reset imem_req", W'(imem_req), '0);
    check("reset ifid_valid", W'(ifid_valid), '0);
    check("reset ifid_instr", ifid_instr, NOP_INSTR);
    check("reset ifid_pc", ifid_pc, '0);
    check("reset PCWrite", W'(PCWrite), '0);
    check("reset npc", npc, 32'h0000_0004);

    do_reset(32'h0000_3000);
    run_vec(0, 20);

    // async reset in the middle of a wait, away from any clock edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst imem_req", W'(imem_req), '0);
    check("async rst ifid_valid", W'(ifid_valid), '0);
    check("async rst ifid_instr", ifid_instr, NOP_INSTR);

    do_reset(32'h0000_3000);
    run_vec(21, 24);

    // randomized traffic against a program-order reference
    do_reset(32'h0000_8000);
    exp_pc     = 32'h0000_8000;
    deliveries = 0;
    quiet      = 0;
    done       = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      r_red   = ($urandom_range(0, 15) == 0);
      r_tgt   = $urandom;
      r_stall = ($urandom_range(0, 3) == 0);
      redirect        = r_red;
      redirect_target = r_tgt;
      id_stall        = r_stall;
      if (imem_req) begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_wait = $urandom_range(0, 3);
          mem_addr = imem_addr;
        end else begin
          check("rand imem_addr stable", imem_addr, mem_addr);
        end
        imem_ack = (mem_wait == 0);
      end else begin
        if (mem_busy) check("rand req dropped before ack", W'(imem_req), W'(1'b1));
        mem_busy = 1'b0;
        imem_ack = 1'b0;
      end
      imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

      @(negedge clk);
      if (r_red) begin
        check("rand redirect PCWrite", W'(PCWrite), W'(1'b1));
        check("rand redirect npc", npc, {r_tgt[W-1:2], 2'b00});
      end else if (r_stall) begin
        check("rand stall PCWrite", W'(PCWrite), '0);
      end else if (PCWrite) begin
        check("rand seq npc", npc, exp_pc + 32'd4);
      end
      s_pcw   = PCWrite;
      s_npc   = npc;
      s_valid = ifid_valid;
      s_instr = ifid_instr;
      s_pc    = ifid_pc;

      @(posedge clk);
      #1;
      if (s_pcw) pc_addr = s_npc;
      if (imem_ack) mem_busy = 1'b0;
      else if (mem_busy) mem_wait--;

      quiet++;
      if (r_red) begin
        check("rand flush valid", W'(ifid_valid), '0);
        check("rand flush instr", ifid_instr, NOP_INSTR);
        exp_pc = {r_tgt[W-1:2], 2'b00};
        quiet  = 0;
      end else if (r_stall) begin
        check("rand hold valid", W'(ifid_valid), W'(s_valid));
        check("rand hold instr", ifid_instr, s_instr);
        check("rand hold pc", ifid_pc, s_pc);
      end else begin
        check("rand delivery vs PCWrite", W'(ifid_valid), W'(s_pcw));
        if (ifid_valid) begin
          check("rand ifid_pc", ifid_pc, exp_pc);
          check("rand ifid_instr", ifid_instr, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          deliveries++;
          quiet = 0;
        end
      end
      if (quiet > 100) begin
        check("rand progress timeout", W'(quiet), W'(100));
        done = 1'b1;
      end
    end
    total++;
    if (deliveries < 200) begin
      bad++;
      $display("FAIL rand delivery count: got %0d expected at least 200", deliveries);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch-side controller that consumes the PC register's current address and drives its npc/PCWrite inputs.
- Fetches instructions over a req/ack instruction-memory handshake and loads the IF/ID pipeline register.
- Stalls the PC while memory is busy or ID is stalled; redirects the PC on branch/jump and squashes wrong-path fetches.

Parameters:
- ADDR_W, 32, address/instruction width.
- NOP_INSTR, 32'h0000_0000, value written to ifid_instr on flush or reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pc_addr  input  ADDR_W  current PC register output.
- npc  output  ADDR_W  next PC value, to the PC register.
- PCWrite  output  1  PC load enable, to the PC register.
- redirect  input  1  branch/jump taken, from EX.
- redirect_target  input  ADDR_W  redirect address; bits [1:0] are ignored and forced to 0.
- id_stall  input  1  ID hazard stall; IF/ID must hold.
- imem_req  output  1  memory request.
- imem_addr  output  ADDR_W  request address.
- imem_ack  input  1  one-cycle completion; imem_rdata is valid this cycle.
- imem_rdata  input  ADDR_W  fetched instruction.
- ifid_valid  output  1  IF/ID holds a valid instruction.
- ifid_instr  output  ADDR_W  IF/ID instruction.
- ifid_pc  output  ADDR_W  IF/ID instruction address.

Behaviour:
Reset (async, immediate):
- state=S_IDLE; imem_req=0; ifid_valid=0; ifid_instr=NOP_INSTR; ifid_pc=0.
- Internal req_addr=0; drop=0; hold_instr=0.

Combinational outputs:
- npc = redirect ? {target[ADDR_W-1:2],2'b00} : req_addr+4, with +4 wrapping modulo 2^ADDR_W.
- PCWrite is high only in the cycles listed below.

Memory protocol:
- imem_addr = req_addr.
- While imem_req is high, imem_addr is stable until imem_ack.
- Back-to-back requests are allowed: req stays high after an ack and the new address applies from the next cycle.

Redirect:
- Redirect has priority over id_stall in every state.
- Any cycle with redirect high: PCWrite=1; IF/ID flushed (valid=0, instr=NOP_INSTR) at the edge.

S_IDLE (imem_req=0):
- If redirect: req_addr<=target.
- Else: req_addr<=pc_addr.
- Next state: S_REQ.

S_REQ (imem_req=1):
- ack & drop: discard rdata; drop<=0; req_addr<=pc_addr (last redirect target); stay.
- ack & redirect: discard rdata; req_addr<=target; stay.
- ack & id_stall: hold_instr<=rdata; PCWrite=0; go S_HOLD.
- ack, otherwise: ifid_instr<=rdata; ifid_pc<=req_addr; ifid_valid<=1; PCWrite=1; req_addr<=req_addr+4; stay.
- No ack & redirect: drop<=1; req_addr unchanged. Repeated redirects while waiting are allowed; PC holds the last one.
- No ack, no redirect: PCWrite=0.

S_HOLD (imem_req=0):
- redirect: discard hold_instr; req_addr<=target; go S_REQ.
- !id_stall: IF/ID<=hold_instr/req_addr; valid<=1; PCWrite=1; req_addr<=req_addr+4; go S_REQ.
- Otherwise: hold.

IF/ID register:
- Holds its contents whenever id_stall=1 and no redirect.
- Otherwise, when no instruction is delivered in a cycle, ifid_valid<=0 (bubble).

Latency:
- Zero-wait memory (ack in the request cycle): 1 instruction/cycle; IF/ID is valid the cycle after the ack.

Reset mid-transaction:
- Request is abandoned. Memory shares rst and must drop its pending transaction.

Decomposition:
- Shared cpu package holds: state enum (S_IDLE, S_REQ, S_HOLD), NOP_INSTR, INSTR_BYTES=4.
- No sub-module. The IF/ID register stays inline because flush and hold are coupled to the FSM.

Test Plan:
- Reset, pc_addr=0x3000, zero-wait memory returning 0x1111_0000+n → imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; PCWrite high every cycle; ifid_pc follows one cycle later.
- Memory ack delayed 3 cycles at 0x3004 → imem_addr stable for 4 cycles; PCWrite=0 for 3 cycles; ifid_valid=0 (bubbles); then ifid_pc=0x3004.
- id_stall for 2 cycles coinciding with ack at 0x3008 → S_HOLD; imem_req=0; IF/ID keeps 0x3004; PCWrite=0; on release ifid_pc=0x3008 and next request is 0x300C.
- redirect to 0x3403 (expect 0x3400) in the cycle after a non-acked request to 0x3010 → npc=0x3400, PCWrite=1; ack for 0x3010 is discarded (ifid_valid stays 0); next imem_addr=0x3400.
- redirect together with id_stall in S_HOLD → redirect wins: flush, PCWrite=1, next imem_addr=target.
- Async rst asserted mid-wait → imem_req=0 and ifid_valid=0 immediately, without waiting for a clock edge. req_addr=0xFFFF_FFFC with no redirect → npc=0x0000_0000 (wrap).
